wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
// - Shares the single register-file write port between the EX/WB pipeline result stream and an auxiliary multi-cycle unit (aux).
// - Pipeline has priority. A starvation counter forces an aux grant and stalls the pipeline for one cycle when aux is blocked too long.
// - Sits between the EX/WB pipeline register, the aux unit and the register-file write port.
// PARAMETERS
// - DATA_W        8  write-data width
// - ADDR_W        3  register address width
// - STARVE_LIMIT  4  consecutive blocked aux cycles before a forced grant (>=1)
// - CNT_W         8  width of the forced-grant statistics counter
// PORTS
// - clk           in   1       one clock
// - rst           in   1       reset is asynchronous and active-high
// - pipe_we       in   1       EX/WB regwrite
// - pipe_rd       in   ADDR_W  EX/WB destination register
// - pipe_data     in   DATA_W  EX/WB ALU result
// - pipe_stall    out  1       hold EX/WB and upstream this cycle
// - aux_valid     in   1       aux result available; held until accepted
// - aux_rd        in   ADDR_W  aux destination register
// - aux_data      in   DATA_W  aux result
// - aux_ready     out  1       aux result accepted this cycle
// - rf_we         out  1       register-file write enable (registered)
// - rf_waddr      out  ADDR_W  register-file write address (registered)
// - rf_wdata      out  DATA_W  register-file write data (registered)
// - force_cnt     out  CNT_W   number of forced aux grants, saturating
// BEHAVIOUR
// - Reset: rf_we=0, rf_waddr=0, rf_wdata=0, force_cnt=0, starve_cnt=0, state=PIPE_PRI.
// - While rst is high: aux_ready=0 and pipe_stall=0.
// - FSM state PIPE_PRI:
//   - pipe_we=1: grant pipe.
//   - pipe_we=0 and aux_valid=1: grant aux; aux_ready=1 combinationally.
//   - Neither request: no grant.
//   - pipe_stall=0.
// - Blocked cycle: pipe_we && aux_valid in PIPE_PRI.
//   - starve_cnt==STARVE_LIMIT-1: next state FORCE_AUX and starve_cnt<=0.
//   - Otherwise starve_cnt increments.
// - starve_cnt<=0 on any cycle with aux_valid=0 or an aux grant.
// - FSM state FORCE_AUX:
//   - pipe_stall=1; the pipeline holds pipe_* stable.
//   - aux_valid=1: grant aux, aux_ready=1, force_cnt += 1 (saturates at 2^CNT_W-1).
//   - aux_valid=0 (protocol violation): no grant, force_cnt unchanged.
//   - Next state is always PIPE_PRI.
// - Latency: a grant in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1.
// - rf_we=0 in any cycle after a no-grant cycle; rf_waddr/rf_wdata hold their previous values.
// - Exactly one source is granted per cycle; a pipe write is never dropped, only delayed by pipe_stall.
// - Same rd from both sources: writes commit in grant order. RAW/WAW ordering is the hazard unit's responsibility.
// - Reset mid-FORCE_AUX: the in-flight aux result is not accepted and aux must re-present it after reset.
// STRUCTURE
// - Shared package wb_arb_pkg: state encoding PIPE_PRI/FORCE_AUX, default DATA_W/ADDR_W.
// - One sub-module, wb_arb_starve_ctr: starve_cnt plus limit compare, outputs force_req.
// - Top level: FSM, grant mux, output register, force_cnt.
// TESTING
// - Pipe only: pipe_we=1, rd=3, data=8'h5A -> next cycle rf_we=1, waddr=3, wdata=8'h5A; aux_ready=0.
// - Aux only: pipe_we=0, aux_valid=1, rd=5, data=8'hC3 -> aux_ready=1 same cycle; next cycle write 5/8'hC3.
// - Starvation (LIMIT=4): pipe_we=1 and aux_valid=1 held from cycle 0 -> pipe writes in cycles 0-3.
//   - Cycle 4: pipe_stall=1, aux_ready=1; cycle 5 rf_* = aux write.
//   - Cycle 5 pipe resumes; force_cnt=1.
// - Counter reset: aux_valid drops at cycle 2 and rises at cycle 3 with pipe_we=1 -> no forced grant before cycle 7.
// - Reset mid-FORCE_AUX: assert rst in cycle 4 of the starvation case -> rf_we=0, aux_ready=0, pipe_stall=0, force_cnt=0 immediately.
// - Saturation (CNT_W=2): 5 forced grants -> force_cnt=3 after the 3rd grant and stays 3.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter: FSM encoding
// and default bus widths.
package wb_arb_pkg;

  typedef enum logic {
    PIPE_PRI  = 1'b0,
    FORCE_AUX = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the pipeline, aux-unit and register-file write-port signals
// handled by wb_port_arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_stall;

  logic              aux_valid;
  logic [ADDR_W-1:0] aux_rd;
  logic [DATA_W-1:0] aux_data;
  logic              aux_ready;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // Arbiter side
  modport slave (
    input  pipe_we, pipe_rd, pipe_data, aux_valid, aux_rd, aux_data,
    output pipe_stall, aux_ready, rf_we, rf_waddr, rf_wdata
  );

  // Pipeline / aux / register-file side
  modport master (
    output pipe_we, pipe_rd, pipe_data, aux_valid, aux_rd, aux_data,
    input  pipe_stall, aux_ready, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_arb_starve_ctr.sv
// Counts consecutive cycles in which aux is blocked by the pipeline and
// raises force_req on the cycle the limit is reached.
module wb_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic blocked,
  output logic force_req
);

  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic          at_limit;

  assign at_limit  = (starve_cnt == SW'(STARVE_LIMIT - 1));
  assign force_req = blocked && at_limit;

  // Any unblocked cycle (aux idle or granted) restarts the count; the limit hit also clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!blocked || at_limit) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the EX/WB pipeline
// (priority) and an aux unit, with a forced aux grant after prolonged starvation.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] force_cnt
);

  arb_state_t        state, next_state;
  logic              grant_pipe, grant_aux, stall, blocked, force_req;
  logic              vld_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0] wdata_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign blocked = (state == PIPE_PRI) && bus.pipe_we && bus.aux_valid;

  wb_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .blocked  (blocked),
    .force_req(force_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PIPE_PRI;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = PIPE_PRI;
    grant_pipe = 1'b0;
    grant_aux  = 1'b0;
    stall      = 1'b0;
    case (state)
      PIPE_PRI: begin
        grant_pipe = bus.pipe_we;
        grant_aux  = !bus.pipe_we && bus.aux_valid;
        if (force_req) next_state = FORCE_AUX;
      end
      FORCE_AUX: begin
        stall     = 1'b1;
        grant_aux = bus.aux_valid;
      end
      default: ;
    endcase
  end

  // Handshakes are suppressed while reset is held so an in-flight aux result is not consumed.
  assign bus.aux_ready  = grant_aux && !rst;
  assign bus.pipe_stall = stall && !rst;

  // Stage p0 -> p1: granted write registered onto the register-file port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      waddr_p1  <= '0;
      wdata_p1  <= '0;
      force_cnt <= '0;
    end else begin
      vld_p1 <= grant_pipe || grant_aux;
      if (grant_pipe) begin
        waddr_p1 <= bus.pipe_rd;
        wdata_p1 <= bus.pipe_data;
      end else if (grant_aux) begin
        waddr_p1 <= bus.aux_rd;
        wdata_p1 <= bus.aux_data;
      end
      if (state == FORCE_AUX && grant_aux) force_cnt <= sat_inc(force_cnt);
    end
  end

  assign bus.rf_we    = vld_p1;
  assign bus.rf_waddr = waddr_p1;
  assign bus.rf_wdata = wdata_p1;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter (STARVE_LIMIT=4, CNT_W=2).
module tb_wb_port_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int LIMIT  = 4;
  localparam int CNT_W  = 2;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] force_cnt;

  wr_t               sb[$];
  int                vectors = 0;
  int                miscompares = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_data = '0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_port_arbiter #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(LIMIT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .force_cnt(force_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic [ADDR_W-1:0] prd, input logic [DATA_W-1:0] pdat,
                       input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] adat);
    bus.pipe_we   = pw;
    bus.pipe_rd   = prd;
    bus.pipe_data = pdat;
    bus.aux_valid = av;
    bus.aux_rd    = ard;
    bus.aux_data  = adat;
  endtask

  // src: 0 = no grant, 1 = pipe, 2 = aux. Entered and left at posedge+1.
  task automatic step(input logic pw, input logic [ADDR_W-1:0] prd, input logic [DATA_W-1:0] pdat,
                      input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] adat,
                      input logic exp_stall, input logic exp_ready, input int src, input string tag);
    wr_t e;
    drive(pw, prd, pdat, av, ard, adat);
    #2;
    chk({tag, "_stall"}, bus.pipe_stall, exp_stall);
    chk({tag, "_ready"}, bus.aux_ready, exp_ready);
    if (src == 1) begin
      last_addr = prd;
      last_data = pdat;
    end else if (src == 2) begin
      last_addr = ard;
      last_data = adat;
    end
    sb.push_back('{we: (src != 0), addr: last_addr, data: last_data});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_we"}, bus.rf_we, e.we);
    chk({tag, "_waddr"}, bus.rf_waddr, e.addr);
    chk({tag, "_wdata"}, bus.rf_wdata, e.data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 3'd6, 8'hA6);
    #12;
    chk("rst_we", bus.rf_we, 1'b0);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_force_cnt", force_cnt, 0);
    chk("rst_ready", bus.aux_ready, 1'b0);
    chk("rst_stall", bus.pipe_stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pipe only, then idle, then aux only, then idle
    step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1, "pipe_only");
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 0, "idle0");
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'hC3, 1'b0, 1'b1, 2, "aux_only");
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 0, "idle1");

    // Starvation: four pipe writes, forced aux in cycle 4, pipe resumes in cycle 5
    for (int i = 0; i < 4; i++)
      step(1'b1, 3'(i), 8'(8'h10 + i), 1'b1, 3'd6, 8'hA6, 1'b0, 1'b0, 1, "starve_pipe");
    step(1'b1, 3'd1, 8'h20, 1'b1, 3'd6, 8'hA6, 1'b1, 1'b1, 2, "starve_force");
    step(1'b1, 3'd1, 8'h20, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1, "starve_resume");
    chk("starve_force_cnt", force_cnt, 1);
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 0, "idle2");

    // Counter reset: aux_valid low in cycle 2 restarts the count, force lands in cycle 7
    for (int i = 0; i < 7; i++)
      step(1'b1, 3'(i), 8'(8'h30 + i), (i != 2), 3'd2, 8'h77, 1'b0, 1'b0, 1, "cntrst_pipe");
    step(1'b1, 3'd7, 8'h37, 1'b1, 3'd2, 8'h77, 1'b1, 1'b1, 2, "cntrst_force");
    step(1'b1, 3'd7, 8'h37, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1, "cntrst_resume");
    chk("cntrst_force_cnt", force_cnt, 2);

    // Reset asserted during FORCE_AUX
    for (int i = 0; i < 4; i++)
      step(1'b1, 3'(i), 8'(8'h40 + i), 1'b1, 3'd6, 8'hA6, 1'b0, 1'b0, 1, "midrst_pipe");
    drive(1'b1, 3'd1, 8'h50, 1'b1, 3'd6, 8'hA6);
    #2;
    chk("midrst_pre_stall", bus.pipe_stall, 1'b1);
    chk("midrst_pre_ready", bus.aux_ready, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_we", bus.rf_we, 1'b0);
    chk("midrst_waddr", bus.rf_waddr, 0);
    chk("midrst_wdata", bus.rf_wdata, 0);
    chk("midrst_ready", bus.aux_ready, 1'b0);
    chk("midrst_stall", bus.pipe_stall, 1'b0);
    chk("midrst_force_cnt", force_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_addr = '0;
    last_data = '0;
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'hA6, 1'b0, 1'b1, 2, "midrst_represent");

    // Saturation of the 2-bit forced-grant counter
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 4; i++)
        step(1'b1, 3'(i), 8'(k * 16 + i), 1'b1, 3'd7, 8'(8'hE0 + k), 1'b0, 1'b0, 1, "sat_pipe");
      step(1'b1, 3'd4, 8'(k * 16 + 4), 1'b1, 3'd7, 8'(8'hE0 + k), 1'b1, 1'b1, 2, "sat_force");
      chk("sat_force_cnt", force_cnt, (k > 3) ? 3 : k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
